// File: rtl/load_store_unit.sv
// load_store_unit
//   CPU-side initiator for a byte-lane data memory port. Accepts one load or
//   store per req_valid/req_ready handshake, drives the memory for exactly one
//   ACCESS cycle, then holds a response until rsp_ready. One access in flight.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_store            1 = store, 0 = load
//   req_funct3           RV32I size/sign code (B/H/W, BU/HU for loads)
//   req_addr, req_wdata  byte address, store data (low bytes used)
//   rsp_valid/rsp_ready  response handshake
//   rsp_data, rsp_err    extended load data (0 for stores/errors), error flag
//   mem_re               read enable code, constant word read
//   mem_we               byte-lane write enables, lane i writes mem_a+i
//   mem_a                base byte address
//   mem_wd1..mem_wd4     lane data, lane 1 = byte at mem_a
//   mem_rd               combinational read data, byte at mem_a in [7:0]

module load_store_unit #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [31:0] MEM_BYTES     = 32'h20000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic [2:0]               mem_re,
  output logic [3:0]               mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [7:0]               mem_wd1,
  output logic [7:0]               mem_wd2,
  output logic [7:0]               mem_wd3,
  output logic [7:0]               mem_wd4,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                   state_q, state_d;
  logic                     store_q, store_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     err_q, err_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;

  logic                     f3_legal;
  logic [ADDRESS_WIDTH:0]   size_m1;
  logic [ADDRESS_WIDTH:0]   last_byte;
  logic                     range_err;
  logic [DATA_WIDTH-1:0]    load_ext;
  logic [3:0]               lane_mask;

  // Request decode, evaluated on the incoming request while IDLE.
  always_comb begin
    f3_legal = 1'b0;
    size_m1  = '0;
    case (req_funct3)
      3'b000:  begin f3_legal = 1'b1;       size_m1 = (ADDRESS_WIDTH+1)'(0); end
      3'b001:  begin f3_legal = 1'b1;       size_m1 = (ADDRESS_WIDTH+1)'(1); end
      3'b010:  begin f3_legal = 1'b1;       size_m1 = (ADDRESS_WIDTH+1)'(3); end
      3'b100:  begin f3_legal = !req_store; size_m1 = (ADDRESS_WIDTH+1)'(0); end
      3'b101:  begin f3_legal = !req_store; size_m1 = (ADDRESS_WIDTH+1)'(1); end
      default: begin f3_legal = 1'b0;       size_m1 = '0;                    end
    endcase
  end

  // One extra bit so an access near the top of the address space cannot wrap
  // back into range.
  assign last_byte = {1'b0, req_addr} + size_m1;
  assign range_err = last_byte >= (ADDRESS_WIDTH+1)'(MEM_BYTES);

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){mem_rd[7]}},   mem_rd[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){mem_rd[15]}}, mem_rd[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},        mem_rd[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}},       mem_rd[15:0]};
      default: load_ext = mem_rd;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = !f3_legal || range_err;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rsp_data_d = (store_q || err_q) ? '0 : load_ext;
        rsp_err_d  = err_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Write enables are gated by rst combinationally so a reset landing on the
  // ACCESS cycle suppresses the write at that same edge.
  assign mem_we    = (state_q == S_ACCESS && store_q && !err_q && !rst) ? lane_mask : 4'b0000;
  assign mem_wd1   = mem_we[0] ? wdata_q[7:0]   : '0;
  assign mem_wd2   = mem_we[1] ? wdata_q[15:8]  : '0;
  assign mem_wd3   = mem_we[2] ? wdata_q[23:16] : '0;
  assign mem_wd4   = mem_we[3] ? wdata_q[31:24] : '0;
  assign mem_a     = addr_q;
  assign mem_re    = 3'b111;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [31:0] MEMB = 32'h20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  mem_re;
  logic [3:0]  mem_we;
  logic [31:0] mem_a;
  logic [7:0]  mem_wd1, mem_wd2, mem_wd3, mem_wd4;
  logic [31:0] mem_rd;

  logic [7:0]  mem [0:MEMB-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_BYTES(MEMB)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd1(mem_wd1), .mem_wd2(mem_wd2), .mem_wd3(mem_wd3), .mem_wd4(mem_wd4),
    .mem_rd(mem_rd)
  );

  // Byte-lane memory model: combinational read, lane writes at the clock edge.
  always @(posedge clk) begin
    if (mem_we[0] && (mem_a + 32'd0) < MEMB) mem[mem_a + 32'd0] <= mem_wd1;
    if (mem_we[1] && (mem_a + 32'd1) < MEMB) mem[mem_a + 32'd1] <= mem_wd2;
    if (mem_we[2] && (mem_a + 32'd2) < MEMB) mem[mem_a + 32'd2] <= mem_wd3;
    if (mem_we[3] && (mem_a + 32'd3) < MEMB) mem[mem_a + 32'd3] <= mem_wd4;
  end

  always_comb begin
    mem_rd = '0;
    for (int unsigned i = 0; i < 4; i++)
      if ((mem_a + i) < MEMB) mem_rd[8*i +: 8] = mem[mem_a + i];
  end

  // Runs one transaction with rsp_ready high; reports what was seen on the
  // memory side during ACCESS and the response.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [3:0] we_s,
                       output logic [31:0] lanes_s, output logic [31:0] a_s,
                       output logic [31:0] data_s, output logic err_s);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    we_s    = mem_we;
    lanes_s = {mem_wd4, mem_wd3, mem_wd2, mem_wd1};
    a_s     = mem_a;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!rsp_valid && cyc < 8);
    checks++;
    if (cyc != 1 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency addr=%h: got %0d cycles rsp_valid=%b, want 1 cycle rsp_valid=1", addr, cyc, rsp_valid);
    end
    data_s = rsp_data;
    err_s  = rsp_err;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake addr=%h: req_ready=%b rsp_valid=%b, want 1/0", addr, req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: valid=%b data=%h err=%b, want 0/0/0", rsp_valid, rsp_data, rsp_err);
    end
    checks++;
    if (mem_we !== 4'b0 || mem_a !== 32'h0 || {mem_wd4, mem_wd3, mem_wd2, mem_wd1} !== 32'h0) begin
      errors++; $display("FAIL reset_mem: we=%b a=%h wd=%h, want 0", mem_we, mem_a, {mem_wd4, mem_wd3, mem_wd2, mem_wd1});
    end
    checks++;
    if (mem_re !== 3'b111 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_re_ready: re=%b ready=%b, want 111/1", mem_re, req_ready);
    end
  endtask

  task automatic test_stores();
    logic [3:0] we; logic [31:0] ln, a, d; logic e;
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, we, ln, a, d, e);
    checks++;
    if (we !== 4'b1111 || ln !== 32'hDEADBEEF || a !== 32'h100) begin
      errors++; $display("FAIL sw_access: we=%b lanes=%h a=%h, want 1111 DEADBEEF 100", we, ln, a);
    end
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL sw_rsp: data=%h err=%b, want 0/0", d, e);
    end
    checks++;
    if ({mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_mem: got %h want DEADBEEF", {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]});
    end
    issue(1'b1, 3'b000, 32'h102, 32'h12345634, we, ln, a, d, e);
    checks++;
    if (we !== 4'b0001 || ln !== 32'h00000034 || e !== 1'b0) begin
      errors++; $display("FAIL sb_access: we=%b lanes=%h err=%b, want 0001 00000034 0", we, ln, e);
    end
    issue(1'b1, 3'b000, 32'h103, 32'hFFFFFF80, we, ln, a, d, e);
    issue(1'b1, 3'b001, 32'h200, 32'hAAAA1234, we, ln, a, d, e);
    checks++;
    if (we !== 4'b0011 || ln !== 32'h00001234 || a !== 32'h200) begin
      errors++; $display("FAIL sh_access: we=%b lanes=%h a=%h, want 0011 00001234 200", we, ln, a);
    end
  endtask

  task automatic test_loads();
    logic [3:0] we; logic [31:0] ln, a, d; logic e;
    issue(1'b0, 3'b000, 32'h103, 32'h0, we, ln, a, d, e);
    checks++;
    if (d !== 32'hFFFFFF80 || e !== 1'b0 || we !== 4'b0) begin
      errors++; $display("FAIL lb: data=%h err=%b we=%b, want FFFFFF80 0 0000", d, e, we);
    end
    issue(1'b0, 3'b100, 32'h103, 32'h0, we, ln, a, d, e);
    checks++;
    if (d !== 32'h00000080 || e !== 1'b0) begin
      errors++; $display("FAIL lbu: data=%h err=%b, want 00000080 0", d, e);
    end
    issue(1'b0, 3'b001, 32'h102, 32'h0, we, ln, a, d, e);
    checks++;
    if (d !== 32'hFFFF8034 || e !== 1'b0) begin
      errors++; $display("FAIL lh: data=%h err=%b, want FFFF8034 0", d, e);
    end
    issue(1'b0, 3'b101, 32'h102, 32'h0, we, ln, a, d, e);
    checks++;
    if (d !== 32'h00008034 || e !== 1'b0) begin
      errors++; $display("FAIL lhu: data=%h err=%b, want 00008034 0", d, e);
    end
    issue(1'b0, 3'b010, 32'h100, 32'h0, we, ln, a, d, e);
    checks++;
    if (d !== 32'h8034BEEF || e !== 1'b0 || a !== 32'h100) begin
      errors++; $display("FAIL lw: data=%h err=%b a=%h, want 8034BEEF 0 100", d, e, a);
    end
  endtask

  task automatic test_errors();
    logic [3:0] we; logic [31:0] ln, a, d; logic e;
    issue(1'b1, 3'b001, 32'h1FFFF, 32'h0000BBCC, we, ln, a, d, e);
    checks++;
    if (we !== 4'b0 || e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL sh_top: we=%b err=%b data=%h, want 0000 1 0", we, e, d);
    end
    issue(1'b1, 3'b000, 32'h1FFFF, 32'h000000A5, we, ln, a, d, e);
    checks++;
    if (we !== 4'b0001 || e !== 1'b0 || ln !== 32'h000000A5) begin
      errors++; $display("FAIL sb_top: we=%b err=%b lanes=%h, want 0001 0 000000A5", we, e, ln);
    end
    issue(1'b0, 3'b100, 32'h1FFFF, 32'h0, we, ln, a, d, e);
    checks++;
    if (d !== 32'h000000A5 || e !== 1'b0) begin
      errors++; $display("FAIL lbu_top: data=%h err=%b, want 000000A5 0", d, e);
    end
    issue(1'b0, 3'b010, 32'h1FFFD, 32'h0, we, ln, a, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL lw_over: data=%h err=%b, want 0 1", d, e);
    end
    issue(1'b0, 3'b010, 32'h1FFFC, 32'h0, we, ln, a, d, e);
    checks++;
    if (e !== 1'b0) begin
      errors++; $display("FAIL lw_last: err=%b, want 0", e);
    end
    issue(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, we, ln, a, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL lw_wrap: err=%b data=%h, want 1 0", e, d);
    end
    issue(1'b0, 3'b011, 32'h100, 32'h0, we, ln, a, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL load_f3_011: err=%b data=%h, want 1 0", e, d);
    end
    issue(1'b1, 3'b100, 32'h100, 32'h11111111, we, ln, a, d, e);
    checks++;
    if (e !== 1'b1 || we !== 4'b0 || mem[32'h100] !== 8'hEF) begin
      errors++; $display("FAIL store_f3_100: err=%b we=%b mem100=%h, want 1 0000 EF", e, we, mem[32'h100]);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h103; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!rsp_valid && cyc < 8);
    // A competing request during the stall must not be taken.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFFFF80 || rsp_err !== 1'b0 ||
          req_ready !== 1'b0 || mem_we !== 4'b0) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b data=%h err=%b ready=%b we=%b, want 1 FFFFFF80 0 0 0000",
                 k, rsp_valid, rsp_data, rsp_err, req_ready, mem_we);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v, exp_r;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b100; req_addr = 32'h103; req_wdata = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = (k == 2 || k == 5);
      exp_r = (k == 3 || k == 6);
      checks++;
      if (rsp_valid !== exp_v || req_ready !== exp_r || (exp_v && rsp_data !== 32'h00000080)) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b ready=%b data=%h, want %b %b 00000080", k, rsp_valid, req_ready, rsp_data, exp_v, exp_r);
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_during_access();
    logic [3:0] we; logic [31:0] ln, a, d; logic e;
    logic seen_v;
    issue(1'b1, 3'b010, 32'h300, 32'h55667788, we, ln, a, d, e);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_we !== 4'b1111) begin
      errors++; $display("FAIL rst_pre_we: we=%b, want 1111", mem_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 4'b0) begin
      errors++; $display("FAIL rst_gate_we: we=%b, want 0000", mem_we);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 || mem_a !== 32'h0 ||
        mem_we !== 4'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_state: valid=%b data=%h err=%b a=%h we=%b ready=%b, want reset values",
               rsp_valid, rsp_data, rsp_err, mem_a, mem_we, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_v = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen_v = 1'b1;
    end
    checks++;
    if (seen_v !== 1'b0) begin
      errors++; $display("FAIL rst_no_rsp: rsp_valid seen=%b, want 0", seen_v);
    end
    issue(1'b0, 3'b010, 32'h300, 32'h0, we, ln, a, d, e);
    checks++;
    if (d !== 32'h55667788 || e !== 1'b0) begin
      errors++; $display("FAIL rst_mem_kept: data=%h err=%b, want 55667788 0", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_during_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
